// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: dynamic-reconfiguration controller for a Gowin rPLL.
// Holds a writable table of divider/phase profiles and sequences PLL reset,
// lock wait with timeout and bounded retry on every profile switch.
// Optional loss-of-lock monitor: define PLL_LOCK_MONITOR_EN.
module pll_dyn_ctrl #(
  parameter int          NUM_PROFILES  = 4,
  parameter logic [29:0] INIT_PROFILE  = 30'h0,
  parameter int          RESET_CYCLES  = 16,
  parameter int          SETTLE_CYCLES = 256,
  parameter int          LOCK_TIMEOUT  = 65535,
  parameter int          MAX_RETRY     = 3,
  localparam int         SW            = $clog2(NUM_PROFILES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_addr,
  input  logic [29:0]   cfg_wdata,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [SW-1:0] req_sel,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    pll_idsel,
  output logic [5:0]    pll_fbdsel,
  output logic [5:0]    pll_odsel,
  output logic [3:0]    pll_psda,
  output logic [3:0]    pll_dutyda,
  output logic [3:0]    pll_fdly,
  output logic [SW-1:0] active_sel,
  output logic          busy,
  output logic          locked,
  output logic          fail,
  output logic          done,
  output logic          err,
  output logic [7:0]    lol_cnt
);
  // The timer is shared: it times the reset pulse, then the lock timeout.
  localparam int TMAX = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int STW  = $clog2(SETTLE_CYCLES + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {RST_ASSERT, WAIT_LOCK, LOCKED, FAIL} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [STW-1:0] stab_q, stab_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [29:0]    cur_q, cur_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           done_q, done_d, err_q, err_d;
  logic           lock_meta_q, lock_s_q;
  logic [29:0]    tbl_q [NUM_PROFILES];
  logic [29:0]    tbl_d [NUM_PROFILES];
  logic [29:0]    req_entry;
  logic           sel_ok, accept;
`ifdef PLL_LOCK_MONITOR_EN
  logic           lol_run_q, lol_run_d;
  logic [7:0]     lol_cnt_q, lol_cnt_d;
`endif

  assign req_ready = (state_q == LOCKED) || (state_q == FAIL);
  assign busy      = (state_q == RST_ASSERT) || (state_q == WAIT_LOCK);
  assign locked    = (state_q == LOCKED);
  assign fail      = (state_q == FAIL);
  assign pll_reset = (state_q == RST_ASSERT);
  assign accept    = req_valid && req_ready;
  assign sel_ok    = 32'(req_sel) < 32'(NUM_PROFILES);
  assign {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly} = cur_q;
  assign active_sel = sel_q;
  assign done       = done_q;
  assign err        = err_q;
`ifdef PLL_LOCK_MONITOR_EN
  assign lol_cnt = lol_cnt_q;
`else
  assign lol_cnt = 8'h00;
`endif

  // Table read (pre-write contents) and write-next-edge; out-of-range indices ignored
  always_comb begin
    req_entry = '0;
    for (int i = 0; i < NUM_PROFILES; i++) begin
      tbl_d[i] = tbl_q[i];
      if (req_sel == SW'(i)) req_entry = tbl_q[i];
      if (cfg_we && cfg_addr == SW'(i)) tbl_d[i] = cfg_wdata;
    end
  end

  // Sequencer next state: reset pulse, lock wait/retry, request handling
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    stab_d  = '0;
    retry_d = retry_q;
    cur_d   = cur_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
    lol_run_d = 1'b0;
    lol_cnt_d = lol_cnt_q;
`endif
    unique case (state_q)
      RST_ASSERT: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TW'(RESET_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
        end
      end
      WAIT_LOCK: begin
        tmr_d  = tmr_q + 1'b1;
        stab_d = lock_s_q ? stab_q + 1'b1 : '0;
        if (lock_s_q && stab_q == STW'(SETTLE_CYCLES - 1)) begin
          state_d = LOCKED;
          retry_d = '0;
          done_d  = 1'b1;
        end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
          tmr_d  = '0;
          stab_d = '0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = RST_ASSERT;
          end else begin
            state_d = FAIL;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        if (accept) begin
          if (!sel_ok) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (state_q == LOCKED && req_entry[29:12] == cur_q[29:12]) begin
            // Dividers unchanged: phase/duty/delay retune without relocking
            cur_d[11:0] = req_entry[11:0];
            sel_d       = req_sel;
            done_d      = 1'b1;
          end else begin
            cur_d   = req_entry;
            sel_d   = req_sel;
            retry_d = '0;
            tmr_d   = '0;
            state_d = RST_ASSERT;
          end
        end
`ifdef PLL_LOCK_MONITOR_EN
        else if (state_q == LOCKED && !lock_s_q) begin
          if (lol_run_q) begin
            lol_cnt_d = (lol_cnt_q == 8'hFF) ? lol_cnt_q : lol_cnt_q + 8'd1;
            retry_d   = '0;
            tmr_d     = '0;
            state_d   = RST_ASSERT;
          end else begin
            lol_run_d = 1'b1;
          end
        end
`endif
      end
    endcase
  end

  // State registers, lock synchroniser and profile table
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_ASSERT;
      tmr_q       <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      cur_q       <= INIT_PROFILE;
      sel_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      for (int i = 0; i < NUM_PROFILES; i++) tbl_q[i] <= INIT_PROFILE;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      cur_q       <= cur_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      for (int i = 0; i < NUM_PROFILES; i++) tbl_q[i] <= tbl_d[i];
    end
  end

`ifdef PLL_LOCK_MONITOR_EN
  // Loss-of-lock monitor state
  always_ff @(posedge clk) begin
    if (reset) begin
      lol_run_q <= 1'b0;
      lol_cnt_q <= 8'h00;
    end else begin
      lol_run_q <= lol_run_d;
      lol_cnt_q <= lol_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// tb_pll_dyn_ctrl: directed scenarios plus randomized traffic, every cycle
// checked against a timestamp-based behavioural model of the controller.
`timescale 1ns/1ps
module tb_pll_dyn_ctrl;
  localparam int NP = 6;
  localparam int SW = $clog2(NP);
  localparam int RC = 16;
  localparam int SC = 32;
  localparam int TO = 100;
  localparam int MR = 3;
  localparam logic [29:0] INIT = 30'h1234_5678;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_addr = '0;
  logic [29:0]   cfg_wdata = '0;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic          pll_lock = 1'b0;
  logic          req_ready, pll_reset, busy, locked, fail, done, err;
  logic [5:0]    pll_idsel, pll_fbdsel, pll_odsel;
  logic [3:0]    pll_psda, pll_dutyda, pll_fdly;
  logic [SW-1:0] active_sel;
  logic [7:0]    lol_cnt;

  always #5 clk = ~clk;

  pll_dyn_ctrl #(.NUM_PROFILES(NP), .INIT_PROFILE(INIT), .RESET_CYCLES(RC),
                 .SETTLE_CYCLES(SC), .LOCK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .pll_psda(pll_psda), .pll_dutyda(pll_dutyda), .pll_fdly(pll_fdly), .active_sel(active_sel),
    .busy(busy), .locked(locked), .fail(fail), .done(done), .err(err), .lol_cnt(lol_cnt));

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = switching (reset pulse then lock wait), 1 = locked, 2 = failed.
  // An attempt starting at cycle t0 drives reset on [t0, t0+RC) and waits from t0+RC.
  logic [29:0] m_tab [NP];
  logic [29:0] m_cur;
  int  m_sel, m_mode, m_t0, m_last0, m_retries, m_zrun, m_lol, m_cyc = 0;
  bit  m_done, m_err, m_valid = 1'b0;
  bit  lock_hist[$] = '{1'b0, 1'b0};
  bit  m_ls;
  int  m_c, m_w0, m_run;

  always @(posedge clk) begin
    m_c  = m_cyc;
    m_ls = lock_hist.pop_front();        // synchronised lock seen during cycle m_c
    lock_hist.push_back(pll_lock);
    if (reset) begin
      for (int i = 0; i < NP; i++) m_tab[i] = INIT;
      m_cur = INIT; m_sel = 0; m_mode = 0; m_t0 = m_c + 1; m_last0 = -1;
      m_retries = 0; m_zrun = 0; m_lol = 0; m_done = 0; m_err = 0;
      lock_hist = '{1'b0, 1'b0};
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_done = 0; m_err = 0;
      if (m_mode == 0) begin
        m_zrun = 0;
        m_w0 = m_t0 + RC;
        if (m_c >= m_w0) begin
          if (!m_ls) m_last0 = m_c;
          m_run = m_c - ((m_last0 > m_w0 - 1) ? m_last0 : m_w0 - 1);
          if (m_run >= SC) begin
            m_mode = 1; m_done = 1; m_retries = 0;
          end else if (m_c - m_w0 + 1 >= TO) begin
            if (m_retries < MR) begin m_retries++; m_t0 = m_c + 1; end
            else begin m_mode = 2; m_done = 1; m_err = 1; end
          end
        end
      end else if (req_valid) begin
        m_zrun = 0;
        if (int'(req_sel) >= NP) begin
          m_done = 1; m_err = 1;
        end else if (m_mode == 1 && m_tab[req_sel][29:12] == m_cur[29:12]) begin
          m_cur[11:0] = m_tab[req_sel][11:0]; m_sel = int'(req_sel); m_done = 1;
        end else begin
          m_cur = m_tab[req_sel]; m_sel = int'(req_sel); m_retries = 0;
          m_mode = 0; m_t0 = m_c + 1;
        end
      end else if (m_mode == 1) begin
`ifdef PLL_LOCK_MONITOR_EN
        m_zrun = m_ls ? 0 : m_zrun + 1;
        if (m_zrun >= 2) begin
          if (m_lol < 255) m_lol++;
          m_mode = 0; m_t0 = m_c + 1; m_retries = 0; m_zrun = 0;
        end
`else
        m_zrun = 0;
`endif
      end else begin
        m_zrun = 0;
      end
      if (cfg_we && int'(cfg_addr) < NP) m_tab[cfg_addr] = cfg_wdata;
    end
    m_cyc = m_c + 1;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid && !reset)
      check("cycle_outputs",
            {16'h0, busy, locked, fail, pll_reset, req_ready, done, err, active_sel,
             pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly, lol_cnt},
            {16'h0, m_mode == 0, m_mode == 1, m_mode == 2, (m_mode == 0) && (m_cyc < m_t0 + RC),
             m_mode != 0, m_done, m_err, SW'(m_sel), m_cur, 8'(m_lol)});
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int a, input logic [29:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = SW'(a); cfg_wdata = d;
    @(negedge clk); cfg_we = 1'b0;
  endtask

  // Returns at the negedge of the cycle after the accepting edge.
  task automatic req(input int sel);
    int n;
    n = 0;
    @(negedge clk); req_valid = 1'b1; req_sel = SW'(sel);
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin total++; bad++; $display("FAIL req_accept: sel %0d never accepted", sel); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound,
                           output int n, output int rc, output int rp, output bit e);
    bit prev;
    n = 0; rc = 0; rp = 0; e = 0; prev = 0;
    while (!done && n < bound) begin
      if (pll_reset) begin rc++; if (!prev) rp++; end
      prev = pll_reset;
      @(negedge clk); n++;
    end
    if (!done) begin total++; bad++; $display("FAIL %s: no done within %0d cycles", name, bound); end
    else e = err;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [29:0] e2, e3, snap;
  int n, rc, rp, seg;
  bit e, prev_rdy;

  initial begin
    e2 = {6'd2, 6'd11, 6'd8, 4'h1, 4'h2, 4'h3};
    e3 = {6'd2, 6'd11, 6'd8, 4'h4, 4'h2, 4'h3};

    // Boot
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_pll_reset", pll_reset, 1);
    check("rst_status", {busy, locked, fail, done, err, req_ready}, 6'b100000);
    check("rst_outputs", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly}, INIT);
    check("rst_sel_lol", {active_sel, lol_cnt}, 0);
    check("model_boot_state", {m_mode == 0, m_cur == INIT, m_sel == 0}, 3'b111);
    repeat (10) @(negedge clk);
    pll_lock = 1'b1;
    wait_done("boot", 500, n, rc, rp, e);
    check("boot_done_cycle", n + 10, RC + SC);
    check("boot_locked_err", {locked, err, pll_reset}, 3'b100);
    check("boot_outputs", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly}, INIT);

    // Full switch
    wr(2, e2);
    req(2);
    wait_done("switch", 500, n, rc, rp, e);
    check("switch_latency", n + 1, RC + SC + 1);
    check("switch_reset_cycles", rc, RC);
    check("switch_dividers", {pll_idsel, pll_fbdsel, pll_odsel}, {6'd2, 6'd11, 6'd8});
    check("switch_sel_err", {active_sel, err, locked}, {SW'(2), 2'b01});
    check("model_switch", {m_cur == e2, m_sel == 2, m_mode == 1}, 3'b111);

    // Fast path
    wr(3, e3);
    req(3);
    check("fast_psda", pll_psda, 4'h4);
    check("fast_flags", {done, err, pll_reset, locked, req_ready}, 5'b10011);
    check("fast_sel", active_sel, 3);

    // Bad selects
    snap = {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly};
    req(6);
    check("badsel6_flags", {done, err, locked, req_ready}, 4'b1111);
    req(7);
    check("badsel7_flags", {done, err, locked, req_ready}, 4'b1111);
    check("badsel_outputs", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly, active_sel},
          {snap, SW'(3)});

    // Write and accept of the same entry in one cycle: request takes old contents
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = SW'(4); cfg_wdata = 30'h0ABC_DEF0;
    req_valid = 1'b1; req_sel = SW'(4);
    @(negedge clk);
    cfg_we = 1'b0; req_valid = 1'b0;
    check("same_cycle_write_latch", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly}, INIT);
    wait_done("same_cycle", 500, n, rc, rp, e);
    check("same_cycle_err", e, 0);

    // Short loss of lock while locked
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    pll_lock = 1'b1;
`ifdef PLL_LOCK_MONITOR_EN
    wait_done("relock", 500, n, rc, rp, e);
    check("lol_count", lol_cnt, 1);
    check("relock_flags", {locked, e, rp}, {2'b10, 32'd1});
`else
    repeat (8) @(negedge clk);
    check("lol_ignored", {locked, busy, lol_cnt}, {2'b10, 8'h00});
`endif

    // Timeout: lock never comes back
    wr(1, {6'd5, 6'd7, 6'd9, 12'hABC});
    pll_lock = 1'b0;
    req(1);
    wait_done("timeout", 4 * (RC + TO) + 50, n, rc, rp, e);
    check("timeout_pulses", rp, MR + 1);
    check("timeout_reset_cycles", rc, (MR + 1) * RC);
    check("timeout_flags", {fail, e, pll_reset, req_ready, busy}, 5'b11010);
    check("fail_holds_profile", {pll_idsel, pll_fbdsel, pll_odsel, active_sel}, {6'd5, 6'd7, 6'd9, SW'(1)});

    // Recover from FAIL
    pll_lock = 1'b1;
    req(2);
    wait_done("recover", 500, n, rc, rp, e);
    check("recover_flags", {locked, fail, e}, 3'b100);

    // Reset mid-switch re-initialises the table
    req(1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midreset_state", {pll_reset, busy, active_sel}, {2'b11, SW'(0)});
    check("midreset_outputs", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly}, INIT);
    wait_done("reboot", 500, n, rc, rp, e);
    req(2);
    check("table_reinit", {done, pll_reset, pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda, pll_fdly},
          {2'b10, INIT});

    // Randomized traffic
    seg = 0; prev_rdy = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 150 == 0) begin
        seg = $urandom_range(0, 9);
      end
      pll_lock = (seg < 6) ? 1'b1 : (seg < 8) ? 1'b0 : ($urandom_range(0, 19) != 0);
      if (i == 2000) reset = 1'b1;
      if (i == 2002) reset = 1'b0;
      if (req_valid && prev_rdy) req_valid = 1'b0;
      if (!req_valid && $urandom_range(0, 19) == 0) begin
        req_valid = 1'b1;
        req_sel = SW'($urandom_range(0, (1 << SW) - 1));
      end
      cfg_we = ($urandom_range(0, 6) == 0);
      cfg_addr = SW'($urandom_range(0, (1 << SW) - 1));
      cfg_wdata = 30'($urandom);
      if ($urandom_range(0, 1) == 1) cfg_wdata[29:12] = {pll_idsel, pll_fbdsel, pll_odsel};
      prev_rdy = req_ready;
    end
    @(negedge clk);
    req_valid = 1'b0; cfg_we = 1'b0; pll_lock = 1'b1;
    repeat (4 * (RC + TO) + 20) @(negedge clk);
    check("drain_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
